// File: rtl/debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
//
// Turns a raw asynchronous level (button, switch, external strobe) into a
// clean level that is synchronous to clk. The input first passes through a
// SYNC_STAGES flip-flop synchronizer. A hold-time filter then accepts a new
// level only after it has been sampled HOLD_CYCLES times in a row. The output
// is meant to feed an edge detector directly.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth, 2..4
//   HOLD_CYCLES  consecutive samples a new level must hold, >= 1
//   RESET_LEVEL  level held by the sync chain and sig_out during reset
//
// Ports:
//   clk         in   single clock, all state updates on posedge
//   reset_n     in   synchronous, active-low reset
//   sig_in      in   raw input, asynchronous to clk
//   sig_out     out  debounced level, registered
//   busy        out  high while a candidate level change is being qualified
//   rise_pulse  out  one-clk pulse when sig_out first shows 1 (optional)
//   fall_pulse  out  one-clk pulse when sig_out first shows 0 (optional)
//
// Build option:
//   DEBOUNCE_EDGE_EN  when defined, adds rise_pulse/fall_pulse and their
//                     registers. sig_out and busy timing are the same in
//                     both builds.
// ---------------------------------------------------------------------------
module debounce_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic sig_out,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sq;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   out_q;
`ifdef DEBOUNCE_EDGE_EN
  logic                   rise_q;
  logic                   fall_q;
`endif

  // The synchronizer shifts toward the MSB. Only its last stage reaches the filter.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign sq     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      out_q   <= RESET_LEVEL;
      cnt_q   <= '0;
      state_q <= STABLE;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      sync_q <= sync_d;
`ifdef DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        STABLE: begin
          if (sq != out_q) begin
            if (HOLD_CYCLES == 1) begin
              // A single sample is enough, so the level is accepted at once.
              out_q <= sq;
`ifdef DEBOUNCE_EDGE_EN
              rise_q <= sq;
              fall_q <= ~sq;
`endif
            end else begin
              // This sample is the first of the HOLD_CYCLES samples needed.
              cnt_q   <= CNT_ONE;
              state_q <= SETTLING;
            end
          end
        end
        SETTLING: begin
          if (sq == out_q) begin
            // The glitch ended. Drop the candidate and keep the output.
            cnt_q   <= '0;
            state_q <= STABLE;
          end else if (cnt_q == CNT_LAST) begin
            out_q   <= sq;
            cnt_q   <= '0;
            state_q <= STABLE;
`ifdef DEBOUNCE_EDGE_EN
            rise_q  <= sq;
            fall_q  <= ~sq;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= STABLE;
        end
      endcase
    end
  end

  assign sig_out = out_q;
  assign busy    = (state_q == SETTLING);
`ifdef DEBOUNCE_EDGE_EN
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`endif

endmodule
